// File: rtl/jace_pkg.sv
// rtl/jace_pkg.sv - shared encodings for the Ace video RAM arbiters.
package jace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RDATA = 2'd1,
    ST_DONE  = 2'd2
  } vram_state_t;

  localparam int VRAM_MAX_WAIT_DEFAULT = 16;

endpackage

// File: rtl/vram_starve_ctr.sv
// rtl/vram_starve_ctr.sv - counts CPU starvation cycles and forces a CPU slot at MAX_WAIT-1.
module vram_starve_ctr
  import jace_pkg::*;
#(
  parameter int MAX_WAIT = VRAM_MAX_WAIT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic idle,
  input  logic cpu_req,
  input  logic vid_req,
  output logic force_cpu
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  logic [7:0] count;

  assign force_cpu = idle & cpu_req & (count == LIMIT);

  // A CPU issue happens in IDLE whenever video is absent or the guard fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (!cpu_req || (idle && (!vid_req || force_cpu))) begin
      count <= '0;
    end else if (idle && vid_req) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port video RAM arbiter: video fetch priority, stalled CPU slots.
// Optional starvation guard enabled by defining VRAM_STARVE_GUARD_EN.
module vram_arbiter
  import jace_pkg::*;
#(
  parameter int AW       = 10,
  parameter int DW       = 8,
  parameter int MAX_WAIT = VRAM_MAX_WAIT_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_wait_n,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_rdata,
  output logic          vid_valid,
  output logic          vid_miss,
  output logic          ram_ce,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  vram_state_t state, state_nxt;
  logic        vid_grant;
  logic        latch_rd;
  logic        force_cpu;

`ifdef VRAM_STARVE_GUARD_EN
  vram_starve_ctr #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve_ctr (
    .clk      (clk),
    .reset    (reset),
    .idle     (state == ST_IDLE),
    .cpu_req  (cpu_req),
    .vid_req  (vid_req),
    .force_cpu(force_cpu)
  );
  assign vid_miss = vid_req & force_cpu & ~reset;
`else
  logic max_wait_unused;
  assign max_wait_unused = (MAX_WAIT > 1);
  assign force_cpu       = 1'b0;
  assign vid_miss        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    vid_grant = 1'b0;
    latch_rd  = 1'b0;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = vid_addr;
    ram_wdata = cpu_wdata;
    case (state)
      ST_IDLE: begin
        if (cpu_req && (!vid_req || force_cpu)) begin
          ram_ce    = 1'b1;
          ram_we    = cpu_we;
          ram_addr  = cpu_addr;
          state_nxt = ST_RDATA;
        end else if (vid_req) begin
          vid_grant = 1'b1;
          ram_ce    = 1'b1;
        end
      end
      // The RAM port is free while the CPU result settles, so video may use it.
      ST_RDATA: begin
        vid_grant = vid_req;
        ram_ce    = vid_req;
        latch_rd  = cpu_req & ~cpu_we;
        state_nxt = cpu_req ? ST_DONE : ST_IDLE;
      end
      ST_DONE: begin
        vid_grant = vid_req;
        ram_ce    = vid_req;
        if (!cpu_req) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cpu_rdata <= '0;
      vid_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      vid_valid <= vid_grant;
      if (latch_rd) begin
        cpu_rdata <= ram_rdata;
      end
    end
  end

  assign cpu_wait_n = reset | ~(cpu_req & (state != ST_DONE));
  assign vid_rdata  = ram_rdata;

endmodule
